// File: rtl/mux_rr_stream.sv
// CH-input stream multiplexer with valid/ready handshakes and a single registered output slot.
// MODE=1 arbitrates round-robin from a rotating pointer; MODE=0 is fixed priority, lowest index wins.
module mux_rr_stream #(
  parameter int unsigned N    = 8,
  parameter int unsigned CH   = 4,
  parameter int unsigned MODE = 1,
  localparam int unsigned SW  = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SW-1:0] ptr_q;
  logic [SW-1:0] start;
  logic [SW-1:0] cand;
  logic [SW-1:0] gnt_idx;
  logic          gnt_found;
  logic          space;
  logic          xfer;

  logic          out_valid_q;
  logic [N-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;

  logic [N-1:0]  chan_data [CH];

  for (genvar i = 0; i < CH; i++) begin : g_chan
    assign chan_data[i] = in_data[i*N +: N];
  end

  always_comb begin
    start     = (MODE == 1) ? ptr_q : '0;
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int unsigned k = 0; k < CH; k++) begin
      // Explicit wrap keeps the candidate below CH when CH is not a power of two.
      if (32'(start) + k >= CH) begin
        cand = SW'(32'(start) + k - CH);
      end else begin
        cand = SW'(32'(start) + k);
      end
      if (!gnt_found && in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign space = !out_valid_q || out_ready;
  assign xfer  = gnt_found && enable && space && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      // A new word overwrites the slot even while the old one drains this edge.
      out_valid_q <= 1'b1;
      out_data_q  <= chan_data[gnt_idx];
      out_sel_q   <= gnt_idx;
      if (MODE == 1) begin
        ptr_q <= (gnt_idx == SW'(CH - 1)) ? '0 : gnt_idx + SW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: a round-robin and a fixed-priority instance share stimulus and are
// compared each cycle against a queue-free arithmetic model of the arbitration rules.
module tb_mux_rr_stream;

  localparam int CH = 4;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic            out_ready;

  logic [CH-1:0]   rr_in_ready, fp_in_ready;
  logic [N-1:0]    rr_out_data, fp_out_data;
  logic [1:0]      rr_out_sel, fp_out_sel;
  logic            rr_out_valid, fp_out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance: 0 = round-robin, 1 = fixed priority.
  logic       mv [2];
  logic [7:0] md [2];
  int         ms [2];
  int         mp [2];

  always #5 clk = ~clk;

  mux_rr_stream #(.N(N), .CH(CH), .MODE(1)) dut_rr (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rr_in_ready),
    .out_data  (rr_out_data),
    .out_sel   (rr_out_sel),
    .out_valid (rr_out_valid),
    .out_ready (out_ready)
  );

  mux_rr_stream #(.N(N), .CH(CH), .MODE(0)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (fp_in_ready),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_valid (fp_out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int grant_of(input int start, input logic [CH-1:0] v);
    for (int k = 0; k < CH; k++) begin
      if (v[(start + k) % CH]) return (start + k) % CH;
    end
    return -1;
  endfunction

  // One clock: check in_ready before the edge, advance the model at the edge, check outputs after.
  task automatic cycle();
    int         g   [2];
    logic       x   [2];
    logic [3:0] exp_ready;
    #1;
    for (int m = 0; m < 2; m++) begin
      g[m] = grant_of((m == 0) ? mp[m] : 0, in_valid);
      x[m] = (g[m] >= 0) && enable && (!mv[m] || out_ready) && !rst;
      exp_ready = x[m] ? 4'(1 << g[m]) : 4'b0;
      check((m == 0) ? "rr_in_ready" : "fp_in_ready",
            32'((m == 0) ? rr_in_ready : fp_in_ready), 32'(exp_ready));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mv[m] = 1'b0; md[m] = 8'h00; ms[m] = 0; mp[m] = 0;
      end else if (x[m]) begin
        mv[m] = 1'b1;
        md[m] = in_data[g[m]*N +: N];
        ms[m] = g[m];
        if (m == 0) mp[m] = (g[m] + 1) % CH;
      end else if (mv[m] && out_ready) begin
        mv[m] = 1'b0;
      end
    end
    @(negedge clk);
    check("rr_out_valid", 32'(rr_out_valid), 32'(mv[0]));
    check("rr_out_data",  32'(rr_out_data),  32'(md[0]));
    check("rr_out_sel",   32'(rr_out_sel),   32'(ms[0]));
    check("fp_out_valid", 32'(fp_out_valid), 32'(mv[1]));
    check("fp_out_data",  32'(fp_out_data),  32'(md[1]));
    check("fp_out_sel",   32'(fp_out_sel),   32'(ms[1]));
  endtask

  task automatic drive(input logic r, input logic en, input logic [3:0] v, input logic ordy);
    rst = r; enable = en; in_valid = v; out_ready = ordy;
  endtask

  logic [7:0] rr_seq_data [4];
  int         rr_seq_sel  [5];

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; md[m] = 8'h00; ms[m] = 0; mp[m] = 0;
    end
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    drive(1'b1, 1'b1, 4'b0000, 1'b0);
    cycle();
    cycle();
    check("reset_valid", 32'(rr_out_valid), 32'd0);

    // Reset mid-operation with A5 held.
    in_data[1*N +: N] = 8'hA5;
    drive(1'b0, 1'b1, 4'b0010, 1'b0);
    cycle();
    check("held_a5", 32'(rr_out_data), 32'hA5);
    drive(1'b1, 1'b1, 4'b0010, 1'b0);
    cycle();
    check("rst_valid", 32'(rr_out_valid), 32'd0);
    check("rst_data",  32'(rr_out_data),  32'h00);
    check("rst_sel",   32'(rr_out_sel),   32'd0);

    // Round-robin fairness; starting at ch0 also shows the pointer was cleared.
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    rr_seq_data = '{8'h10, 8'h21, 8'h32, 8'h43};
    rr_seq_sel  = '{0, 1, 2, 3, 0};
    drive(1'b0, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_seq_sel",  32'(rr_out_sel),  32'(rr_seq_sel[i]));
      check("rr_seq_data", 32'(rr_out_data), 32'(rr_seq_data[rr_seq_sel[i]]));
      check("rr_seq_valid", 32'(rr_out_valid), 32'd1);
      check("fp_seq_sel",  32'(fp_out_sel),  32'd0);
    end

    // Wrap and skip.
    drive(1'b0, 1'b1, 4'b1000, 1'b1);
    cycle();
    check("wrap_g3", 32'(rr_out_sel), 32'd3);
    drive(1'b0, 1'b1, 4'b0101, 1'b1);
    cycle();
    check("wrap_g0", 32'(rr_out_sel), 32'd0);
    cycle();
    check("skip_g2", 32'(rr_out_sel), 32'd2);
    drive(1'b0, 1'b1, 4'b0001, 1'b1);
    cycle();
    check("wrap2_g0", 32'(rr_out_sel), 32'd0);

    // Backpressure: drain, then load 5A and hold it.
    drive(1'b0, 1'b1, 4'b0000, 1'b1);
    cycle();
    in_data[1*N +: N] = 8'h5A;
    drive(1'b0, 1'b1, 4'b0010, 1'b0);
    cycle();
    check("bp_data", 32'(rr_out_data), 32'h5A);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_ready", 32'(rr_in_ready), 32'd0);
      check("bp_hold",  32'(rr_out_data), 32'h5A);
    end
    in_data[1*N +: N] = 8'h6B;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(rr_in_ready), 32'b0010);
    cycle();
    check("bp_release_data", 32'(rr_out_data), 32'h6B);

    // enable gating: held word drains, pointer (now 2) stays frozen.
    drive(1'b0, 1'b0, 4'b1111, 1'b0);
    cycle();
    check("en_hold", 32'(rr_out_valid), 32'd1);
    drive(1'b0, 1'b0, 4'b1111, 1'b1);
    cycle();
    check("en_drain", 32'(rr_out_valid), 32'd0);
    drive(1'b0, 1'b1, 4'b1111, 1'b1);
    cycle();
    check("en_ptr", 32'(rr_out_sel), 32'd2);

    // Fixed priority never reaches ch2/ch3 while ch1 requests.
    drive(1'b0, 1'b1, 4'b1110, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("fp_sel1", 32'(fp_out_sel), 32'd1);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_data = $urandom();
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
            4'($urandom()), ($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
